dm_access_ctrl: RTL and testbench
=================================

# dm_access_ctrl

Data-memory access controller for the MEM stage. Accepts one load/store request at a time from the pipeline and validates alignment. It generates word-aligned bus address, byte enables and lane-aligned store data, and runs a req/ack handshake with a variable-latency data bus. It stalls the pipeline until the access completes, then returns the raw read word with the type code and byte offset needed by the load-extension unit.

## Interface
Parameters:
- TIMEOUT, 16: bus cycles to wait for bus_ack before abort (used only with DM_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  MEM stage has an access this cycle
- req_we  in  1  1 = store, 0 = load
- req_type  in  4  width code:
  - 0000 word
  - 0010/0011 half
  - 0100/0101 byte
  - 0110 LWL/SWL
  - 0111 LWR/SWR
  - any other code is treated as word
- req_addr  in  32  byte address
- req_wdata  in  32  store source register value
- req_ready  out  1  controller idle, request accepted this cycle
- stall  out  1  hold pipeline
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  raw bus word, unshifted
- rsp_type  out  4  latched req_type
- rsp_byte_select  out  2  latched req_addr[1:0]
- exc_adel  out  1  misaligned load
- exc_ades  out  1  misaligned store
- bus_req  out  1  bus request, held until ack
- bus_we  out  1  bus write
- bus_addr  out  32  {req_addr[31:2],2'b00}
- bus_be  out  4  byte enables, bit i = byte lane i
- bus_wdata  out  32  lane-aligned store data
- bus_ack  in  1  bus completes the access in this cycle
- bus_rdata  in  32  valid when bus_ack=1
- bus_err  out  1  timeout abort pulse; tied 0 without DM_TIMEOUT_EN

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid with an aligned request, latch we/type/addr/wdata and go to BUS.
  - On req_valid with a misaligned request, do not latch and stay in IDLE.
- BUS:
  - bus_req=1; all bus_* outputs are driven from latched values and stay stable.
  - On bus_ack, latch bus_rdata (loads) and go to RESP.
- RESP: rsp_valid=1 for one cycle, then go to IDLE.
- Alignment rules:
  - word: addr[1:0]=00.
  - half: addr[0]=0.
  - byte, L/R: any address.
  - Misalignment raises exc_adel or exc_ades, selected by req_we.
  - The exception output is combinational and valid in the same cycle as req_valid in IDLE.
  - A misaligned request causes no bus activity and no stall.
- Byte enables, a = addr[1:0]:
  - loads: 1111.
  - word store: 1111.
  - half store: a[1] ? 1100 : 0011.
  - byte store: 0001<<a.
  - SWL: a=0→0001, 1→0011, 2→0111, 3→1111.
  - SWR: a=0→1111, 1→1110, 2→1100, 3→1000.
- Store data:
  - half: {wdata[15:0],wdata[15:0]}.
  - byte: wdata[7:0] replicated 4×.
  - SWL: wdata >> 8·(3−a).
  - SWR: wdata << 8·a.
  - word: unchanged.
- stall = (IDLE & req_valid & aligned) | BUS. stall is 0 in RESP, so the pipeline advances with rsp_valid.
- rsp_rdata, rsp_type and rsp_byte_select hold their values until the next completion.

## Timing
- Reset values:
  - state IDLE.
  - bus_req, bus_we, rsp_valid, bus_err = 0.
  - bus_be = 0000.
  - bus_addr, bus_wdata, rsp_rdata = 0.
  - rsp_type = 0000, rsp_byte_select = 00.
- Reset mid-access drops bus_req immediately (asynchronously). Any in-flight ack is lost.
- Request accepted at edge 0 → bus_req high in cycle 1.
- Ack sampled at edge k → rsp_valid in cycle k+1.
- Minimum latency: 2 cycles (ack in cycle 1 → RESP in cycle 2).
- bus_ack is ignored while bus_req=0.
- req_valid is ignored outside IDLE; the pipeline is stalled then, so the request is held.
- A new request may be accepted in the cycle after RESP; there is no back-to-back overlap.

## Configuration
- DM_TIMEOUT_EN defined:
  - A counter clears on entry to BUS and increments each BUS cycle without ack.
  - When the count reaches TIMEOUT−1 with no ack: drop bus_req, set rsp_rdata=0, go to RESP.
  - bus_err pulses together with that rsp_valid.
  - An ack in the same cycle as the timeout wins: normal completion, bus_err stays 0.
- Undefined: the controller waits in BUS indefinitely and bus_err is tied to 0.

## Test plan
- Load word at 0x100, ack after 3 cycles with 0xDEADBEEF:
  - bus_addr=0x100, bus_be=1111.
  - stall high for 4 cycles.
  - rsp_valid pulse with rsp_rdata=0xDEADBEEF and rsp_byte_select=00.
- Byte store 0xAB at 0x203 (type 0100), immediate ack → bus_addr=0x200, bus_be=1000, bus_wdata=0xABABABAB, rsp_valid in cycle 2.
- SWL at a=1 with wdata=0x11223344 → bus_be=0011, bus_wdata=0x00001122.
- SWR at a=2 with the same wdata → bus_be=1100, bus_wdata=0x33440000.
- Half load at 0x101 → exc_adel=1 in the same cycle, bus_req stays 0, stall=0.
- Word store at 0x102 → exc_ades=1.
- Assert reset_n low during BUS → bus_req falls immediately; after release the controller is in IDLE with req_ready=1.
- With DM_TIMEOUT_EN and TIMEOUT=16, never ack → bus_req drops after 16 BUS cycles; rsp_valid and bus_err pulse together with rsp_rdata=0.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory access controller: alignment, lane steering, bus req/ack.
// Optional bus-timeout abort is enabled by defining DM_TIMEOUT_EN.
module dm_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [3:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [3:0]  rsp_type,
  output logic [1:0]  rsp_byte_select,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state;
  logic [1:0]  a;
  logic        is_half;
  logic        is_byte;
  logic        is_swl;
  logic        is_swr;
  logic        aligned;
  logic        accept;
  logic        timeout;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [3:0]  lat_type;
  logic [1:0]  lat_sel;

  assign a       = req_addr[1:0];
  assign is_half = req_type[3:1] == 3'b001;
  assign is_byte = req_type[3:1] == 3'b010;
  assign is_swl  = req_type == 4'b0110;
  assign is_swr  = req_type == 4'b0111;

  // Unlisted type codes fall through to word handling.
  always_comb begin
    aligned = 1'b1;
    be      = 4'b1111;
    wd      = req_wdata;
    unique case (1'b1)
      is_half: begin
        aligned = ~a[0];
        be      = a[1] ? 4'b1100 : 4'b0011;
        wd      = {2{req_wdata[15:0]}};
      end
      is_byte: begin
        be = 4'b0001 << a;
        wd = {4{req_wdata[7:0]}};
      end
      is_swl: begin
        be = 4'b1111 >> ~a;
        wd = req_wdata >> {~a, 3'b000};
      end
      is_swr: begin
        be = 4'b1111 << a;
        wd = req_wdata << {a, 3'b000};
      end
      default: aligned = (a == 2'b00);
    endcase
    if (!req_we) be = 4'b1111;
  end

  assign req_ready = state == IDLE;
  assign accept    = req_ready & req_valid & aligned;
  assign exc_adel  = req_ready & req_valid & ~aligned & ~req_we;
  assign exc_ades  = req_ready & req_valid & ~aligned & req_we;
  assign stall     = accept | (state == BUS);

`ifdef DM_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt;
  assign timeout = cnt == CW'(TIMEOUT - 1);
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      bus_req         <= 1'b0;
      bus_we          <= 1'b0;
      bus_addr        <= '0;
      bus_be          <= '0;
      bus_wdata       <= '0;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_type        <= '0;
      rsp_byte_select <= '0;
      lat_type        <= '0;
      lat_sel         <= '0;
`ifdef DM_TIMEOUT_EN
      cnt             <= '0;
      bus_err         <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
`ifdef DM_TIMEOUT_EN
      bus_err   <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (accept) begin
            state     <= BUS;
            bus_req   <= 1'b1;
            bus_we    <= req_we;
            bus_addr  <= {req_addr[31:2], 2'b00};
            bus_be    <= be;
            bus_wdata <= wd;
            lat_type  <= req_type;
            lat_sel   <= a;
`ifdef DM_TIMEOUT_EN
            cnt       <= '0;
`endif
          end
        end
        BUS: begin
          if (bus_ack || timeout) begin
            state           <= RESP;
            bus_req         <= 1'b0;
            rsp_valid       <= 1'b1;
            rsp_type        <= lat_type;
            rsp_byte_select <= lat_sel;
            // Ack wins over a coincident timeout.
            if (!bus_ack) rsp_rdata <= '0;
            else if (!bus_we) rsp_rdata <= bus_rdata;
`ifdef DM_TIMEOUT_EN
            bus_err         <= ~bus_ack;
`endif
          end
`ifdef DM_TIMEOUT_EN
          else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Randomized bench for dm_access_ctrl against a lane-level reference model.
// Timeout case is exercised only when DM_TIMEOUT_EN is defined.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_we;
  logic [3:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [3:0]  rsp_type;
  logic [1:0]  rsp_byte_select;
  logic        exc_adel;
  logic        exc_ades;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_rdata = '0;

  always #5 clk = ~clk;

  dm_access_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_we(req_we),
    .req_type(req_type), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .stall(stall), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_type(rsp_type),
    .rsp_byte_select(rsp_byte_select),
    .exc_adel(exc_adel), .exc_ades(exc_ades),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-lane view: each byte lane's enable and source byte.
  function automatic void model(input logic we, input logic [3:0] ty,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic ok, output logic [3:0] be,
                                output logic [31:0] sd);
    int a;
    int kind;
    a = int'(addr[1:0]);
    if (ty == 4'd2 || ty == 4'd3) kind = 1;
    else if (ty == 4'd4 || ty == 4'd5) kind = 2;
    else if (ty == 4'd6) kind = 3;
    else if (ty == 4'd7) kind = 4;
    else kind = 0;
    ok = (kind == 0) ? (a == 0) : (kind == 1) ? (a % 2 == 0) : 1'b1;
    be = '0;
    sd = '0;
    for (int i = 0; i < 4; i++) begin
      logic en;
      int src;
      en = 1'b1;
      src = i;
      case (kind)
        1: begin en = (i / 2) == (a / 2); src = i % 2; end
        2: begin en = (i == a); src = 0; end
        3: begin en = (i <= a); src = (i <= a) ? i + 3 - a : -1; end
        4: begin en = (i >= a); src = (i >= a) ? i - a : -1; end
        default: ;
      endcase
      be[i] = we ? en : 1'b1;
      if (src >= 0) sd[8*i +: 8] = wd[8*src +: 8];
    end
  endfunction

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      req_valid = 1'b0;
      bus_ack   = 1'($urandom);
      bus_rdata = $urandom;
      @(negedge clk);
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_bus_req", bus_req, 0);
      check("idle_ready", req_ready, 1);
      check("idle_stall", stall, 0);
      check("idle_rdata_hold", rsp_rdata, exp_rdata);
      @(posedge clk);
      #1;
      bus_ack = 1'b0;
    end
  endtask

  // Starts at posedge+1 in IDLE, returns at posedge+1 back in IDLE.
  task automatic access(input logic we, input logic [3:0] ty,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int dly, input logic [31:0] rd);
    logic ok;
    logic [3:0] ebe;
    logic [31:0] ewd;
    model(we, ty, addr, wd, ok, ebe, ewd);
    req_valid = 1'b1;
    req_we    = we;
    req_type  = ty;
    req_addr  = addr;
    req_wdata = wd;
    bus_ack   = 1'b0;
    @(negedge clk);
    check("req_ready", req_ready, 1);
    check("stall_accept", stall, 32'(ok));
    check("exc_adel", exc_adel, 32'(!ok && !we));
    check("exc_ades", exc_ades, 32'(!ok && we));
    if (!ok) begin
      check("misal_bus_req", bus_req, 0);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("misal_no_req", bus_req, 0);
      check("misal_ready", req_ready, 1);
      @(posedge clk);
      #1;
    end else begin
      for (int c = 0; c <= dly; c++) begin
        @(posedge clk);
        #1;
        bus_ack   = (c == dly);
        bus_rdata = (c == dly) ? rd : $urandom;
        @(negedge clk);
        check("bus_req", bus_req, 1);
        check("bus_we", bus_we, 32'(we));
        check("bus_addr", bus_addr, {addr[31:2], 2'b00});
        check("bus_be", bus_be, 32'(ebe));
        if (we) check("bus_wdata", bus_wdata, ewd);
        check("stall_bus", stall, 1);
        check("ready_bus", req_ready, 0);
        check("rsp_valid_bus", rsp_valid, 0);
      end
      @(posedge clk);
      #1;
      bus_ack   = 1'b0;
      req_valid = 1'b0;
      if (!we) exp_rdata = rd;
      @(negedge clk);
      check("rsp_valid", rsp_valid, 1);
      check("stall_resp", stall, 0);
      check("bus_req_resp", bus_req, 0);
      check("bus_err", bus_err, 0);
      check("rsp_rdata", rsp_rdata, exp_rdata);
      check("rsp_type", rsp_type, 32'(ty));
      check("rsp_sel", rsp_byte_select, 32'(addr[1:0]));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_type  = '0;
    req_addr  = '0;
    req_wdata = '0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_bus_be", bus_be, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_type", rsp_type, 0);
    check("rst_rsp_sel", rsp_byte_select, 0);
    check("rst_ready", req_ready, 1);
    check("rst_stall", stall, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    access(1'b0, 4'b0000, 32'h100, 32'h0, 2, 32'hDEADBEEF);
    idle(1);
    access(1'b1, 4'b0100, 32'h203, 32'h000000AB, 0, 32'h0);
    access(1'b1, 4'b0110, 32'h301, 32'h11223344, 1, 32'h0);
    access(1'b1, 4'b0111, 32'h302, 32'h11223344, 0, 32'h0);
    access(1'b0, 4'b0010, 32'h101, 32'h0, 0, 32'h0);
    access(1'b1, 4'b0000, 32'h102, 32'h0, 0, 32'h0);
    idle(3);

    for (int t = 0; t < 250; t++) begin
      access(1'($urandom), 4'($urandom), $urandom, $urandom,
             int'($urandom_range(0, 4)), $urandom);
      idle(int'($urandom_range(0, 2)));
    end

    // Async reset in the middle of a bus access.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_type  = 4'b0000;
    req_addr  = 32'h400;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_bus_req", bus_req, 1);
    #2;
    req_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    check("async_drop_req", bus_req, 0);
    check("async_ready", req_ready, 1);
    exp_rdata = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2);

`ifdef DM_TIMEOUT_EN
    access(1'b0, 4'b0000, 32'h800, 32'h0, 0, 32'h12345678);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_type  = 4'b0000;
    req_addr  = 32'h900;
    bus_ack   = 1'b0;
    for (int c = 0; c < 17; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (c < 16) begin
        check("to_bus_req", bus_req, 1);
        check("to_no_rsp", rsp_valid, 0);
      end
    end
    req_valid = 1'b0;
    exp_rdata = '0;
    check("to_req_drop", bus_req, 0);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_bus_err", bus_err, 1);
    check("to_rdata", rsp_rdata, 0);
    @(posedge clk);
    #1;
    idle(1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
